// File: rtl/lfsr_reg_bank.sv
// Multi-channel register bank. Each channel has its own Galois LFSR; writes come from switches or from LFSR steps.
// Optional write counter: define LFSR_BANK_WRCNT_EN to build wr_count, otherwise it is tied to zero.
module lfsr_reg_bank #(
    parameter int              WIDTH        = 16,
    parameter int              NCH          = 4,
    parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'h1ACE,
    parameter int              DB_CYC       = 1_000_000,
    parameter int              HOLD_CYC     = 50_000_000,
    parameter int              REP_CYC      = 500_000,
    localparam int             CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             we_manual,
    input  logic             btn_step,
    input  logic [CW-1:0]    wr_ch,
    input  logic [CW-1:0]    rd_ch,
    output logic [WIDTH-1:0] rd_data,
    output logic             wr_pulse,
    output logic [15:0]      wr_count
);

    localparam int            DB_W      = $clog2(DB_CYC + 1);
    localparam int            CNT_MAX   = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int            CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
    localparam logic [CW:0]      NCH_W     = (CW + 1)'(NCH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DELAY = 2'd1, ST_REPEAT = 2'd2} state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    // Per-channel seed; an all-zero LFSR would lock up, so it falls back to the default.
    function automatic logic [WIDTH-1:0] seed_value(input logic [WIDTH-1:0] s, input int ch);
        logic [WIDTH-1:0] t;
        t = s ^ WIDTH'(ch);
        return (t == {WIDTH{1'b0}}) ? SEED_DEFAULT : t;
    endfunction

    logic             rst_meta_r, rst_sync_r;
    logic [1:0]       mode_sync_r, we_sync_r, btn_sync_r;
    logic             mode_s, mode_d_r, seed_load_s;
    logic [DB_W-1:0]  we_db_cnt_r, btn_db_cnt_r;
    logic             we_db_r, we_db_d_r, btn_db_r, btn_db_d_r;
    logic             we_press_s, btn_press_s;
    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] rep_cnt_r, rep_cnt_nx_s;
    logic             step_req_s, wr_ok_s;
    logic [WIDTH-1:0] seed_src_s, step_val_s;
    logic [WIDTH-1:0] regs_r [NCH];
    logic [WIDTH-1:0] lfsr_r [NCH];
    logic             wr_pulse_r;

    // Reset synchroniser: asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Two-flop synchronisers for the raw board inputs, plus mode edge history.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            mode_sync_r <= 2'b00;
            we_sync_r   <= 2'b00;
            btn_sync_r  <= 2'b00;
            mode_d_r    <= 1'b0;
        end else begin
            mode_sync_r <= {mode_sync_r[0], mode};
            we_sync_r   <= {we_sync_r[0], we_manual};
            btn_sync_r  <= {btn_sync_r[0], btn_step};
            mode_d_r    <= mode_s;
        end
    end

    assign mode_s      = mode_sync_r[1];
    assign seed_load_s = mode_s & ~mode_d_r;

    // Debouncer for we_manual: state follows only after DB_CYC consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            we_db_cnt_r <= {DB_W{1'b0}};
            we_db_r     <= 1'b0;
            we_db_d_r   <= 1'b0;
        end else begin
            we_db_d_r <= we_db_r;
            if (we_sync_r[1] == we_db_r) begin
                we_db_cnt_r <= {DB_W{1'b0}};
            end else if (we_db_cnt_r == DB_LAST) begin
                we_db_cnt_r <= {DB_W{1'b0}};
                we_db_r     <= we_sync_r[1];
            end else begin
                we_db_cnt_r <= we_db_cnt_r + DB_W'(1);
            end
        end
    end

    // Debouncer for btn_step, same scheme as we_manual.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            btn_db_cnt_r <= {DB_W{1'b0}};
            btn_db_r     <= 1'b0;
            btn_db_d_r   <= 1'b0;
        end else begin
            btn_db_d_r <= btn_db_r;
            if (btn_sync_r[1] == btn_db_r) begin
                btn_db_cnt_r <= {DB_W{1'b0}};
            end else if (btn_db_cnt_r == DB_LAST) begin
                btn_db_cnt_r <= {DB_W{1'b0}};
                btn_db_r     <= btn_sync_r[1];
            end else begin
                btn_db_cnt_r <= btn_db_cnt_r + DB_W'(1);
            end
        end
    end

    assign we_press_s  = we_db_r & ~we_db_d_r;
    assign btn_press_s = btn_db_r & ~btn_db_d_r;

    // Repeat FSM state register.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            state_r   <= ST_IDLE;
            rep_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            rep_cnt_r <= rep_cnt_nx_s;
        end
    end

    // Repeat FSM next state: one step on press, then hold delay, then periodic auto-repeat.
    always_comb begin
        state_nx_s   = state_r;
        rep_cnt_nx_s = rep_cnt_r;
        step_req_s   = 1'b0;
        if (!mode_s) begin
            state_nx_s   = ST_IDLE;
            rep_cnt_nx_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (btn_press_s) begin
                        step_req_s   = 1'b1;
                        state_nx_s   = ST_DELAY;
                        rep_cnt_nx_s = {CNT_W{1'b0}};
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (!btn_db_r) begin
                        state_nx_s   = ST_IDLE;
                        rep_cnt_nx_s = {CNT_W{1'b0}};
                    end else if (rep_cnt_r == HOLD_LAST) begin
                        step_req_s   = 1'b1;
                        state_nx_s   = ST_REPEAT;
                        rep_cnt_nx_s = {CNT_W{1'b0}};
                    end else begin
                        rep_cnt_nx_s = rep_cnt_r + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!btn_db_r) begin
                        state_nx_s   = ST_IDLE;
                        rep_cnt_nx_s = {CNT_W{1'b0}};
                    end else if (rep_cnt_r == REP_LAST) begin
                        step_req_s   = 1'b1;
                        rep_cnt_nx_s = {CNT_W{1'b0}};
                    end else begin
                        rep_cnt_nx_s = rep_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s   = ST_IDLE;
                    rep_cnt_nx_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign wr_ok_s    = ({1'b0, wr_ch} < NCH_W);
    assign seed_src_s = (sw_data == {WIDTH{1'b0}}) ? SEED_DEFAULT : sw_data;
    assign step_val_s = lfsr_next(lfsr_r[wr_ch]);

    // Register/LFSR update; seed load beats a step, and a bad channel drops the write.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            for (int i = 0; i < NCH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
                lfsr_r[i] <= seed_value(SEED_DEFAULT, i);
            end
            wr_pulse_r <= 1'b0;
        end else begin
            wr_pulse_r <= 1'b0;
            if (seed_load_s) begin
                for (int i = 0; i < NCH; i++) begin
                    lfsr_r[i] <= seed_value(seed_src_s, i);
                end
            end else if (step_req_s && wr_ok_s) begin
                lfsr_r[wr_ch] <= step_val_s;
                regs_r[wr_ch] <= step_val_s;
                wr_pulse_r    <= 1'b1;
            end else if (!mode_s && we_press_s && wr_ok_s) begin
                regs_r[wr_ch] <= sw_data;
                wr_pulse_r    <= 1'b1;
            end else begin
                wr_pulse_r <= 1'b0;
            end
        end
    end

    assign rd_data  = ({1'b0, rd_ch} < NCH_W) ? regs_r[rd_ch] : {WIDTH{1'b0}};
    assign wr_pulse = wr_pulse_r;

`ifdef LFSR_BANK_WRCNT_EN
    logic [15:0] wr_count_r;

    // Saturating count of visible register updates.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            wr_count_r <= 16'h0000;
        end else if (wr_pulse_r && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'h0001;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    assign wr_count = wr_count_r;
`else
    assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_reg_bank.sv
// Directed bench for lfsr_reg_bank with a scoreboard of expected register writes checked on each wr_pulse.
module tb_lfsr_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n, mode, we_manual, btn_step;
    logic [15:0] sw_data, rd_data, wr_count;
    logic [1:0]  wr_ch, rd_ch;
    logic        wr_pulse;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          cyc    = 0;
    int          base, rst_base, exp_cnt;
    logic [15:0] exp_q [$];
    int          pcyc [$];
    logic [15:0] m_lfsr [4];
    logic [1:0]  wch [3];
    logic [15:0] wval [3];

    always #5 clk = ~clk;

    lfsr_reg_bank #(
        .WIDTH(16), .NCH(4), .TAPS(16'hB400), .SEED_DEFAULT(16'h1ACE),
        .DB_CYC(4), .HOLD_CYC(20), .REP_CYC(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sw_data(sw_data),
        .we_manual(we_manual), .btn_step(btn_step), .wr_ch(wr_ch), .rd_ch(rd_ch),
        .rd_data(rd_data), .wr_pulse(wr_pulse), .wr_count(wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic seed_model(input logic [15:0] s);
        logic [15:0] base_s, t;
        base_s = (s == 16'h0000) ? 16'h1ACE : s;
        for (int c = 0; c < 4; c++) begin
            t = base_s ^ 16'(c);
            m_lfsr[c] = (t == 16'h0000) ? 16'h1ACE : t;
        end
    endtask

    task automatic model_step(input int c);
        m_lfsr[c] = m_step(m_lfsr[c]);
        exp_q.push_back(m_lfsr[c]);
    endtask

    task automatic check_reg(input int c, input logic [15:0] exp, input string tag);
        logic [1:0] keep;
        keep  = rd_ch;
        rd_ch = 2'(c);
        #1;
        chk(tag, rd_data, exp);
        rd_ch = keep;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n;
        n = 0;
        while (pulses < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("pulse_wait", (pulses >= target) ? 1 : 0, 1);
    endtask

    task automatic press_btn(input int len);
        btn_step = 1'b1;
        tick(len);
        btn_step = 1'b0;
        tick(12);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b1; sw_data = 16'h0000; we_manual = 1'b0;
        btn_step = 1'b0; wr_ch = 2'd0; rd_ch = 2'd0;

        // Monitor: every wr_pulse pops one expected value and compares it with rd_data.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (wr_pulse === 1'b1) begin
                    pulses++;
                    pcyc.push_back(cyc);
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_pulse observed=%0h expected=none", rd_data);
                    end
                    if (exp_q.size() > 0) chk("pulse_data", rd_data, exp_q.pop_front());
                end
            end
        join_none

        // 1: reset state, then seed load after release with no write
        tick(3);
        for (int c = 0; c < 4; c++) begin
            rd_ch = 2'(c);
            #1;
            chk($sformatf("rst_rd%0d", c), rd_data, 16'h0000);
        end
        chk("rst_pulse", wr_pulse, 1'b0);
        rst_n = 1'b1;
        tick(12);
        seed_model(16'h0000);
        chk("seed_no_pulse", pulses, 0);

        // 2: manual write on channel 2, then a too-short glitch
        mode = 1'b0;
        tick(5);
        wr_ch = 2'd2; rd_ch = 2'd2; sw_data = 16'h1234;
        base = pulses;
        exp_q.push_back(16'h1234);
        we_manual = 1'b1;
        tick(10);
        we_manual = 1'b0;
        tick(10);
        chk("man_pulses", pulses - base, 1);
        check_reg(0, 16'h0000, "man_reg0");
        check_reg(1, 16'h0000, "man_reg1");
        check_reg(2, 16'h1234, "man_reg2");
        check_reg(3, 16'h0000, "man_reg3");
        base = pulses;
        sw_data = 16'h5555;
        we_manual = 1'b1;
        tick(2);
        we_manual = 1'b0;
        tick(12);
        chk("glitch_pulses", pulses - base, 0);
        check_reg(2, 16'h1234, "glitch_reg2");

        // 3: seed from zero switches, single steps on channels 0 and 1
        sw_data = 16'h0000;
        mode = 1'b1;
        tick(6);
        seed_model(16'h0000);
        wr_ch = 2'd0; rd_ch = 2'd0;
        model_step(0);
        press_btn(8);
        check_reg(0, 16'h0D67, "step_ch0");
        wr_ch = 2'd1; rd_ch = 2'd1;
        model_step(1);
        press_btn(8);
        check_reg(1, 16'hB967, "step_ch1");

        // 4: held button, delay then auto-repeat
        wr_ch = 2'd3; rd_ch = 2'd3;
        for (int i = 0; i < 17; i++) model_step(3);
        pcyc.delete();
        base = pulses;
        btn_step = 1'b1;
        tick(100);
        btn_step = 1'b0;
        tick(30);
        chk("hold_pulses", pulses - base, 17);
        chk("hold_q_empty", exp_q.size(), 0);
        if (pcyc.size() == 17) begin
            for (int i = 1; i < 17; i++)
                chk($sformatf("hold_gap%0d", i), pcyc[i] - pcyc[0], 20 + 5 * (i - 1));
        end

        // 5a: leaving LFSR mode mid-repeat stops stepping
        wr_ch = 2'd0; rd_ch = 2'd0;
        for (int i = 0; i < 3; i++) model_step(0);
        base = pulses;
        btn_step = 1'b1;
        wait_pulses(base + 3, 200);
        mode = 1'b0;
        tick(40);
        btn_step = 1'b0;
        tick(12);
        chk("mode_abort_pulses", pulses - base, 3);
        chk("mode_abort_q", exp_q.size(), 0);

        // 5b: nonzero seed, reset during the hold delay
        sw_data = 16'h00A5;
        mode = 1'b1;
        tick(6);
        seed_model(16'h00A5);
        wr_ch = 2'd2; rd_ch = 2'd2;
        model_step(2);
        base = pulses;
        btn_step = 1'b1;
        wait_pulses(base + 1, 100);
        tick(5);
        rst_n = 1'b0;
        btn_step = 1'b0;
        #1;
        chk("rst_async_rd", rd_data, 16'h0000);
        chk("rst_async_pulse", wr_pulse, 1'b0);
        for (int c = 0; c < 4; c++) check_reg(c, 16'h0000, $sformatf("rst_reg%0d", c));
        tick(3);
        rst_n = 1'b1;
        seed_model(16'h00A5);
        base = pulses;
        tick(40);
        chk("rst_no_repeat", pulses - base, 0);
        model_step(2);
        press_btn(8);
        check_reg(2, 16'hB453, "post_rst_step");

        // 6: write counter after three manual writes
        mode = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(8);
        rst_base = pulses;
        chk("wrcnt_rst", wr_count, 16'h0000);
        wch[0] = 2'd0; wch[1] = 2'd1; wch[2] = 2'd3;
        wval[0] = 16'hBEEF; wval[1] = 16'h0001; wval[2] = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            wr_ch = wch[k]; rd_ch = wch[k]; sw_data = wval[k];
            exp_q.push_back(wval[k]);
            we_manual = 1'b1;
            tick(8);
            we_manual = 1'b0;
            tick(10);
        end
        tick(3);
        chk("wrcnt_pulses", pulses - rst_base, 3);
        for (int k = 0; k < 3; k++) check_reg(int'(wch[k]), wval[k], $sformatf("wrcnt_reg%0d", k));
`ifdef LFSR_BANK_WRCNT_EN
        exp_cnt = pulses - rst_base;
`else
        exp_cnt = 0;
`endif
        chk("wr_count", wr_count, exp_cnt);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
